// File: rtl/arcade_cfg_pkg.sv
// rtl/arcade_cfg_pkg.sv - shared constants and types for the arcade config/input front end
package arcade_cfg_pkg;
  localparam logic [7:0] DIP_INDEX    = 8'd254;
  localparam logic [7:0] MOD_INDEX    = 8'd1;
  localparam int         JOY_COIN_BIT = 7;

  typedef logic [15:0] joy_word_t;
endpackage

// File: rtl/arcade_cfg_inputs_coin_stretch.sv
// rtl/arcade_cfg_inputs_coin_stretch.sv - per-player coin pulse stretcher (module coin_stretch)
module coin_stretch #(
  parameter int PULSE = 600000
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic coin_in,
  output logic coin_out
);
  localparam int CW = $clog2(PULSE + 1);

  logic [CW-1:0] cnt;
  logic          coin_d;

  // Only a fresh rising edge while idle starts a pulse; a held coin never retriggers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      coin_d <= 1'b0;
    end else begin
      coin_d <= coin_in;
      if (cnt != '0)
        cnt <= cnt - CW'(1);
      else if (coin_in && !coin_d)
        cnt <= CW'(PULSE);
    end
  end

  assign coin_out = (cnt != '0);
endmodule

// File: rtl/arcade_cfg_inputs.sv
// rtl/arcade_cfg_inputs.sv - HPS download capture of core-select/DIP bytes plus joystick repackaging.
// Define ARCADE_COIN_STRETCH_EN to enable per-player coin pulse stretching.
module arcade_cfg_inputs
  import arcade_cfg_pkg::*;
#(
  parameter int NUM_SW      = 8,
  parameter int NUM_PLAYERS = 2,
  parameter int MOD_COUNT   = 18,
  parameter int COIN_PULSE  = 600000
) (
  input  logic                      clk_sys,
  input  logic                      rst_n,
  input  logic                      ioctl_download,
  input  logic                      ioctl_wr,
  input  logic [7:0]                ioctl_index,
  input  logic [24:0]               ioctl_addr,
  input  logic [7:0]                ioctl_dout,
  input  logic [16*NUM_PLAYERS-1:0] joy_in,
  output logic [16*NUM_PLAYERS-1:0] joy_out,
  output logic [15:0]               joy_any,
  output logic [8*NUM_SW-1:0]       sw_out,
  output logic [7:0]                mod_out,
  output logic [MOD_COUNT-1:0]      mod_onehot,
  output logic                      cfg_valid,
  output logic                      cfg_update
);
  logic [8*NUM_SW-1:0] shadow_sw;
  logic [7:0]          shadow_mod;
  logic                dl_d;
  logic                dl_seen;
  logic                armed;
  logic                wr_ok;
  logic                commit;

  assign wr_ok  = ioctl_wr && ioctl_download;
  assign commit = dl_d && !ioctl_download && armed;

  // dl_seen masks the first sample after reset so a download already in flight never arms.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      shadow_sw  <= '0;
      shadow_mod <= '0;
      dl_d       <= 1'b0;
      dl_seen    <= 1'b0;
      armed      <= 1'b0;
      sw_out     <= '0;
      mod_out    <= '0;
      mod_onehot <= '0;
      cfg_valid  <= 1'b0;
      cfg_update <= 1'b0;
    end else begin
      dl_d       <= ioctl_download;
      dl_seen    <= 1'b1;
      cfg_update <= commit;
      if (wr_ok && ioctl_index == DIP_INDEX) begin
        for (int i = 0; i < NUM_SW; i++)
          if (ioctl_addr == 25'(i)) shadow_sw[8*i +: 8] <= ioctl_dout;
      end
      if (wr_ok && ioctl_index == MOD_INDEX && ioctl_addr == '0)
        shadow_mod <= ioctl_dout;
      if (commit) begin
        sw_out    <= shadow_sw;
        mod_out   <= shadow_mod;
        cfg_valid <= 1'b1;
        armed     <= 1'b0;
        for (int i = 0; i < MOD_COUNT; i++)
          mod_onehot[i] <= (shadow_mod == 8'(i));
      end else if (dl_seen && ioctl_download && !dl_d) begin
        armed <= 1'b1;
      end
    end
  end

  logic [NUM_PLAYERS-1:0] coin_s;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
`ifdef ARCADE_COIN_STRETCH_EN
    coin_stretch #(.PULSE(COIN_PULSE)) u_coin (
      .clk_sys  (clk_sys),
      .rst_n    (rst_n),
      .coin_in  (joy_in[16*p + JOY_COIN_BIT]),
      .coin_out (coin_s[p])
    );
`else
    assign coin_s[p] = joy_in[16*p + JOY_COIN_BIT];
`endif
  end

  logic [16*NUM_PLAYERS-1:0] joy_next;

  always_comb begin
    joy_next = joy_in;
    for (int p = 0; p < NUM_PLAYERS; p++)
      joy_next[16*p + JOY_COIN_BIT] = coin_s[p];
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) joy_out <= '0;
    else        joy_out <= joy_next;
  end

  always_comb begin
    joy_word_t acc;
    acc = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      acc = acc | joy_out[16*p +: 16];
    joy_any = acc;
  end
endmodule

// File: tb/tb_arcade_cfg_inputs.sv
// tb/tb_arcade_cfg_inputs.sv - directed self-checking bench for arcade_cfg_inputs
module tb_arcade_cfg_inputs;
  localparam int NUM_SW = 8, NUM_PLAYERS = 2, MOD_COUNT = 18, COIN_PULSE = 10;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [31:0] joy_in = 32'd0;
  logic [31:0] joy_out;
  logic [15:0] joy_any;
  logic [63:0] sw_out;
  logic [7:0]  mod_out;
  logic [17:0] mod_onehot;
  logic        cfg_valid, cfg_update;

  int n_tests = 0;
  int n_fail  = 0;

  arcade_cfg_inputs #(
    .NUM_SW(NUM_SW), .NUM_PLAYERS(NUM_PLAYERS), .MOD_COUNT(MOD_COUNT), .COIN_PULSE(COIN_PULSE)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .joy_in(joy_in), .joy_out(joy_out), .joy_any(joy_any), .sw_out(sw_out), .mod_out(mod_out),
    .mod_onehot(mod_onehot), .cfg_valid(cfg_valid), .cfg_update(cfg_update)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = addr; ioctl_dout = data;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx; ioctl_download = 1'b1;
    tick();
  endtask

  // Coin drive schedule: high for ticks [0,a) and [b,c); counts ticks where player-0 coin out is high.
  task automatic coin_run(input string tag, input int a, input int b, input int c,
                          input int exp_first, input int exp_count);
    int first = -1, count = 0;
    for (int t = 0; t < 40; t++) begin
      joy_in[7] = (t < a) || (t >= b && t < c);
      tick();
      if (joy_out[7]) begin
        count++;
        if (first < 0) first = t;
      end
    end
    check({tag, "_first"}, 64'(first), 64'(exp_first));
    check({tag, "_count"}, 64'(count), 64'(exp_count));
  endtask

  initial begin
    tick(); tick();
    check("reset_sw", sw_out, 64'd0);
    check("reset_misc", {joy_out, mod_out, mod_onehot, cfg_valid, cfg_update},
          64'd0);
    rst_n = 1'b1;
    tick();

    // DIP download of 0x11..0x18
    start_dl(8'd254);
    for (int i = 0; i < 8; i++) wr_byte(8'd254, 25'(i), 8'(8'h11 + i));
    check("sw_hidden_during_dl", sw_out, 64'd0);
    ioctl_download = 1'b0;
    tick();
    check("sw_commit", sw_out, 64'h1817161514131211);
    check("update_pulse", {62'd0, cfg_update, cfg_valid}, 64'd3);
    tick();
    check("update_one_cycle", {63'd0, cfg_update}, 64'd0);

    // core select 5, with an ignored address 1 write
    start_dl(8'd1);
    wr_byte(8'd1, 25'd0, 8'd5);
    wr_byte(8'd1, 25'd1, 8'd7);
    ioctl_download = 1'b0;
    tick();
    check("mod5", {mod_out, 46'(mod_onehot)}, {8'd5, 46'h00020});
    check("sw_kept", sw_out, 64'h1817161514131211);
    tick();

    // core select 40: out of range for one-hot
    start_dl(8'd1);
    wr_byte(8'd1, 25'd0, 8'd40);
    ioctl_download = 1'b0;
    tick();
    check("mod40", {mod_out, 46'(mod_onehot), 1'b0, cfg_valid}, {8'd40, 46'd0, 2'b01});
    tick();

    // out-of-range address 9 ignored, byte 0 rewritten, outputs stable mid-download
    start_dl(8'd254);
    wr_byte(8'd254, 25'd9, 8'hAA);
    wr_byte(8'd254, 25'd0, 8'h99);
    wr_byte(8'd254, 25'd8, 8'hBB);
    check("sw_stable_mid_dl", sw_out, 64'h1817161514131211);
    ioctl_download = 1'b0;
    tick();
    check("sw_partial_commit", sw_out, 64'h1817161514131299);
    tick();

    // empty download still commits and pulses
    start_dl(8'd254);
    tick();
    ioctl_download = 1'b0;
    tick();
    check("empty_commit", {cfg_update, sw_out[62:0]}, {1'b1, 63'h1817161514131299});
    tick();

    // async reset mid-download, released while download is still high
    start_dl(8'd254);
    rst_n = 1'b0;
    #1;
    check("async_reset", {sw_out[55:0], mod_out}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    wr_byte(8'd254, 25'd0, 8'h55);
    ioctl_download = 1'b0;
    tick();
    check("no_commit_unarmed", {61'd0, cfg_update, cfg_valid, |sw_out}, 64'd0);
    tick();
    check("no_pulse_later", {63'd0, cfg_update}, 64'd0);
    start_dl(8'd254);
    ioctl_download = 1'b0;
    tick();
    check("shadow_kept_after_skip", sw_out, 64'h55);

    // joystick pass-through and OR
    joy_in = {16'h0410, 16'h0003};
    tick();
    check("joy_pass", {32'd0, joy_out}, {32'd0, 16'h0410, 16'h0003});
    check("joy_any", {48'd0, joy_any}, {48'd0, 16'h0413});
    joy_in = 32'd0;
    tick(); tick();

`ifdef ARCADE_COIN_STRETCH_EN
    coin_run("coin3", 3, 99, 99, 1, COIN_PULSE);
    coin_run("coin_reedge", 3, 5, 8, 1, COIN_PULSE);
    coin_run("coin_held", 30, 99, 99, 1, COIN_PULSE);
`else
    coin_run("coin3", 3, 99, 99, 0, 3);
    coin_run("coin_reedge", 3, 5, 8, 0, 6);
    coin_run("coin_held", 30, 99, 99, 0, 30);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/arcade_cfg_inputs.md
# arcade_cfg_inputs

Parametrised configuration-and-input front end for arcade cores. It captures the per-game core-select byte and the DIP-switch bytes from the HPS download stream into shadow registers and commits them atomically when the download completes. It also repackages N players' joystick words, with per-player coin pulse stretching, for the game core. It sits between `hps_io` and the game module in `emu` and replaces ad-hoc `mod`/`sw[]` capture logic.

## Interface
Parameters:
- `NUM_SW`, 8: number of DIP/switch bytes captured (1..32).
- `NUM_PLAYERS`, 2: number of joystick words (1..4).
- `MOD_COUNT`, 18: width of the one-hot core-select output (1..64).
- `COIN_PULSE`, 600000: stretched coin width in `clk_sys` cycles (≥1; 50 ms at 12 MHz).

Ports:
- `clk_sys` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: download in progress.
- `ioctl_wr` in 1: download byte strobe.
- `ioctl_index` in 8: download target index.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `joy_in` in 16*NUM_PLAYERS: raw joystick words, player p at `[16p+15:16p]`, bit 7 = coin.
- `joy_out` out 16*NUM_PLAYERS: joystick words with coin bit replaced by the stretched coin.
- `joy_any` out 16: bitwise OR of all `joy_out` words.
- `sw_out` out 8*NUM_SW: committed switch bytes, byte i at `[8i+7:8i]`.
- `mod_out` out 8: committed core-select byte.
- `mod_onehot` out MOD_COUNT: one-hot decode of `mod_out`.
- `cfg_valid` out 1: at least one download has been committed since reset.
- `cfg_update` out 1: one-cycle pulse on each commit.

## Operation
- Capture accepts a write only when `ioctl_wr & ioctl_download` are both high:
  - `ioctl_index==DIP_INDEX` (254) and `ioctl_addr < NUM_SW`: `shadow_sw[addr] <= dout`. Addresses ≥ NUM_SW are ignored.
  - `ioctl_index==MOD_INDEX` (1) and `ioctl_addr==0`: `shadow_mod <= dout`. Other addresses are ignored.
- Arming: a rising edge of `ioctl_download` (previous sample 0, current 1) sets `armed`.
- Commit: a falling edge (`dl_d==1`, `ioctl_download==0`) with `armed==1` performs, at that clock edge:
  - `sw_out <= shadow_sw`, `mod_out <= shadow_mod`;
  - `cfg_valid <= 1`, `cfg_update <= 1`, `armed <= 0`.
  - Shadows are not cleared, so bytes not rewritten keep their previous values.
- A falling edge without `armed` (reset released mid-download) does not commit.
- Committed outputs are stable throughout a download.
- `mod_onehot` is registered and updated on the same edge as `mod_out`: bit `mod_out` is set if `cfg_valid` and `mod_out < MOD_COUNT`; otherwise all zero.
- Coin stretcher, per player:
  - A rising edge of the raw coin bit while idle loads the counter with `COIN_PULSE`. The coin output is high while the counter is nonzero.
  - Edges during an active pulse are ignored.
  - A coin held past expiry does not retrigger; it must go low, then high again.
- All other `joy_in` bits pass through registered, so every `joy_out` bit has one cycle of latency. `joy_any` is combinational from `joy_out`.

## Timing
- Reset values: all outputs 0; shadows 0; `armed`=0, `dl_d`=0; coin counters and edge registers 0.
- Capture latency: a write at edge t is in the shadow after t. It is not visible on outputs until commit.
- Commit latency: outputs change at the first edge that samples `ioctl_download` low. `cfg_update` is high for exactly that following cycle.
- Back-to-back downloads each commit independently. A download with no accepted writes still commits, re-asserting unchanged values and pulsing `cfg_update`.
- Coin: raw rising edge sampled at edge t gives the coin output high from after t+1 for exactly `COIN_PULSE` cycles.
- Counter width is `$clog2(COIN_PULSE+1)`.
- Reset asserted mid-pulse or mid-download clears all state immediately, asynchronously.

## Configuration
- `ARCADE_COIN_STRETCH_EN` defined: the stretcher is as specified.
- Not defined: no counters are instantiated, and each coin bit is the raw coin registered with one cycle of latency, like the other bits. `COIN_PULSE` is unused.

## Structure
- Package `arcade_cfg_pkg` holds:
  - `DIP_INDEX` = 8'd254, `MOD_INDEX` = 8'd1, `JOY_COIN_BIT` = 7;
  - typedef `joy_word_t` (logic [15:0]).
- Sub-module `coin_stretch` (parameter `PULSE`): one instance per player via generate, present only under the macro.

## Test plan
- Download index 254 with bytes 0x11..0x18 at addresses 0..7 (NUM_SW=8), then drop `ioctl_download` → `sw_out` = 0x1817161514131211 on the falling-edge sample; `cfg_update` high one cycle; `cfg_valid`=1.
- Download index 1 with byte 5 → `mod_out`=5, `mod_onehot`=18'h00020. Repeat with byte 40 → `mod_onehot`=0, `cfg_valid` stays 1.
- During an active download, write address 9 (NUM_SW=8) and toggle bytes → `sw_out` unchanged until commit; address 9 never appears.
- Release `rst_n` while `ioctl_download`=1, write bytes, then drop download → no commit, `cfg_update` never pulses, outputs remain 0.
- Macro on, COIN_PULSE=10: coin high 3 cycles → coin out high exactly 10 cycles. Second edge at cycle 5 → no extension. Coin held 30 cycles → one 10-cycle pulse only.
- Macro off: coin high 3 cycles → coin out high 3 cycles, delayed by 1. `joy_any` equals the OR of both players' `joy_out` words.
